// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between an instruction-fetch port (I) and a
// load/store port (D). One 1-cycle access is granted at a time. Round-robin
// applies only when both ports are eligible at the same IDLE edge. The memory
// strobes come straight from registers, so ren and wen are never high together.
// A saturating counter records every grant decision made under contention.
module mem_port_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    // instruction-fetch port (read only)
    input  logic             i_req,
    input  logic [AW-1:0]    i_addr,
    output logic [DW-1:0]    i_rdata,
    output logic             i_ack,
    // load/store port
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    output logic [DW-1:0]    d_rdata,
    output logic             d_ack,
    // memory side
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_din,
    input  logic [DW-1:0]    mem_dout,
    // performance debug
    output logic [CNT_W-1:0] contention
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0] state;
    logic       last_grant_d;   // 1: D won the most recent contended decision
    logic       i_elig;
    logic       d_elig;
    logic       contend;
    logic       grant_i;
    logic       grant_d;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Grant decision. A request seen while its own ack is still high belongs
    // to the transaction just completed, so it is not eligible again.
    always_comb begin
        i_elig  = i_req & ~i_ack;
        d_elig  = d_req & ~d_ack;
        contend = (state == IDLE) & i_elig & d_elig;
        grant_i = (state == IDLE) & i_elig & (~d_elig | last_grant_d);
        grant_d = (state == IDLE) & d_elig & (~i_elig | ~last_grant_d);
    end

    // Control: FSM, ack pulses, round-robin pointer and contention counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            contention   <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
        end else begin
            i_ack <= (state == SERVE_I);
            d_ack <= (state == SERVE_D);
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state <= SERVE_I;
                    end else if (grant_d) begin
                        state <= SERVE_D;
                    end
                end
                default: state <= IDLE;
            endcase
            if (contend) begin
                last_grant_d <= grant_d;
                contention   <= sat_inc(contention);
            end
        end
    end

    // Memory drive registers: loaded on a grant, strobes cleared leaving SERVE.
    // Address and write data simply hold between accesses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (grant_i) begin
            mem_ren  <= 1'b1;
            mem_wen  <= 1'b0;
            mem_addr <= i_addr;
        end else if (grant_d) begin
            mem_ren  <= ~d_we;
            mem_wen  <= d_we;
            mem_addr <= d_addr;
            mem_din  <= d_wdata;
        end else if (state != IDLE) begin
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
        end
    end

    // Read data capture: changes only on the edge that raises the matching
    // ack. Stores leave d_rdata untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (state == SERVE_I) begin
                i_rdata <= mem_dout;
            end
            if ((state == SERVE_D) && !mem_wen) begin
                d_rdata <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios, then randomized traffic
// checked against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             i_req;
    logic [AW-1:0]    i_addr;
    logic [DW-1:0]    i_rdata;
    logic             i_ack;
    logic             d_req;
    logic             d_we;
    logic [AW-1:0]    d_addr;
    logic [DW-1:0]    d_wdata;
    logic [DW-1:0]    d_rdata;
    logic             d_ack;
    logic             mem_ren;
    logic             mem_wen;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_din;
    logic [DW-1:0]    mem_dout;
    logic [CNT_W-1:0] contention;

    int checks   = 0;
    int failures = 0;

    // memory environment plus backdoor preload
    logic [DW-1:0] mem     [0:63] = '{default: '0};
    logic [DW-1:0] ref_mem [0:63] = '{default: '0};
    logic          bd_en = 1'b0;
    logic [5:0]    bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ack      (i_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .contention (contention)
    );

    always #5 clock = ~clock;

    assign mem_dout = mem[mem_addr[5:0]];

    always @(negedge clock) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (mem_wen) mem[mem_addr[5:0]] <= mem_din;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bd_write(input logic [5:0] a, input logic [DW-1:0] v);
        bd_addr = a;
        bd_data = v;
        bd_en   = 1'b1;
        @(negedge clock);
        #1;
        bd_en      = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic do_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Run until both ports have been acked, dropping each request at its ack.
    task automatic drain(input int limit);
        int c;
        c = 0;
        while ((i_req || d_req) && c < limit) begin
            tick();
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
            c++;
        end
        if (i_req || d_req) begin
            chk("drain_timeout", 64'd1, 64'd0);
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    initial begin
        int            n;
        int            seq [12];
        logic          overlap;
        logic          i_pend, d_pend, d_pwe;
        int            i_wait, d_wait, i_others, d_others;
        logic [5:0]    ia, da;
        logic [DW-1:0] dwd, i_exp, d_exp;

        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_contention", contention, 0);
        reset = 1'b1;

        // ---------------- single fetch
        bd_write(6'd4, 32'h1234);
        tick();
        i_addr = 32'd4; i_req = 1'b1;
        tick();
        chk("fetch_ren", mem_ren, 1);
        chk("fetch_addr", mem_addr, 4);
        chk("fetch_ack_early", i_ack, 0);
        tick();
        chk("fetch_ack", i_ack, 1);
        chk("fetch_rdata", i_rdata, 32'h1234);
        chk("fetch_ren_clr", mem_ren, 0);
        i_req = 1'b0;
        tick();
        chk("fetch_ack_pulse", i_ack, 0);
        chk("fetch_rdata_hold", i_rdata, 32'h1234);

        // ---------------- store then load
        d_we = 1'b1; d_addr = 32'd8; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        tick();
        chk("store_wen", mem_wen, 1);
        chk("store_ren", mem_ren, 0);
        chk("store_din", mem_din, 32'hDEADBEEF);
        chk("store_addr", mem_addr, 8);
        tick();
        chk("store_ack", d_ack, 1);
        chk("store_wen_clr", mem_wen, 0);
        chk("store_rdata_hold", d_rdata, 0);
        ref_mem[8] = 32'hDEADBEEF;
        d_we = 1'b0;
        tick();
        chk("load_ignored_during_ack", mem_ren, 0);
        chk("store_ack_pulse", d_ack, 0);
        chk("store_wen_once", mem_wen, 0);
        tick();
        chk("load_ren", mem_ren, 1);
        chk("load_addr", mem_addr, 8);
        tick();
        chk("load_ack", d_ack, 1);
        chk("load_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;

        // ---------------- simultaneous requests from reset
        do_reset();
        i_addr = 32'd4; d_addr = 32'd8; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        tick();
        chk("simul_first_is_i", mem_addr, 4);
        chk("simul_contention", contention, 1);
        tick();
        chk("simul_i_ack", i_ack, 1);
        chk("simul_d_not_yet", d_ack, 0);
        i_req = 1'b0;
        tick();
        chk("simul_second_is_d", mem_addr, 8);
        tick();
        chk("simul_d_ack", d_ack, 1);
        chk("simul_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("simul_contention_hold", contention, 1);
        d_req = 1'b0;
        tick();

        // ---------------- continuous contention
        do_reset();
        i_req = 1'b1; d_req = 1'b1;
        n = 0; overlap = 1'b0;
        for (int c = 0; c < 60 && n < 12; c++) begin
            tick();
            if (mem_ren && mem_wen) overlap = 1'b1;
            if (i_ack) begin seq[n] = 0; n = n + 1; end
            else if (d_ack) begin seq[n] = 1; n = n + 1; end
        end
        chk("cont_ack_count", n, 12);
        for (int k = 0; k < 12; k++) chk($sformatf("cont_order_%0d", k), seq[k], k % 2);
        chk("cont_no_overlap", overlap, 0);
        chk("cont_contention", contention, 1);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // ---------------- reset during SERVE_D store
        do_reset();
        bd_write(6'd20, 32'h5555);
        tick();
        d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'hAAAA; d_req = 1'b1;
        tick();
        chk("abort_store_granted", mem_wen, 1);
        reset = 1'b0;
        #1;
        chk("abort_wen", mem_wen, 0);
        chk("abort_ren", mem_ren, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_din", mem_din, 0);
        chk("abort_contention", contention, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("abort_no_ack_a", d_ack, 0);
        tick();
        chk("abort_no_ack_b", d_ack, 0);
        chk("abort_mem_unchanged", mem[20], 32'h5555);
        reset = 1'b1;
        tick();
        chk("abort_no_ack_c", d_ack, 0);
        i_addr = 32'd4; d_addr = 32'd20;
        i_req = 1'b1; d_req = 1'b1;
        tick();
        chk("abort_first_grant_i", mem_addr, 4);
        chk("abort_contention_after", contention, 1);
        drain(20);

        // ---------------- counter saturation
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            i_req = 1'b1; d_req = 1'b1;
            drain(20);
            tick();
            chk($sformatf("sat_count_%0d", e), contention, (e > 3) ? 3 : e);
        end
        tick();
        chk("sat_hold", contention, 3);

        // ---------------- randomized traffic
        do_reset();
        i_pend = 1'b0; d_pend = 1'b0; d_pwe = 1'b0;
        i_wait = 0; d_wait = 0; i_others = 0; d_others = 0;
        ia = '0; da = '0; dwd = '0;
        i_exp = '0; d_exp = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            chk("rnd_ren_wen_excl", mem_ren & mem_wen, 0);
            if (i_ack) begin
                chk("rnd_i_ack_expected", i_pend, 1);
                chk("rnd_i_fair", (i_others <= 1), 1);
                i_exp  = ref_mem[ia];
                i_pend = 1'b0; i_req = 1'b0;
                if (d_pend) d_others++;
            end
            if (d_ack) begin
                chk("rnd_d_ack_expected", d_pend, 1);
                chk("rnd_d_fair", (d_others <= 1), 1);
                if (d_pwe) ref_mem[da] = dwd;
                else d_exp = ref_mem[da];
                d_pend = 1'b0; d_req = 1'b0;
                if (i_pend) i_others++;
            end
            chk("rnd_i_rdata", i_rdata, i_exp);
            chk("rnd_d_rdata", d_rdata, d_exp);
            if (i_pend) begin
                i_wait++;
                if (i_wait > 8) begin
                    chk("rnd_i_timeout", 64'd0, 64'd1);
                    i_pend = 1'b0; i_req = 1'b0;
                end
            end
            if (d_pend) begin
                d_wait++;
                if (d_wait > 8) begin
                    chk("rnd_d_timeout", 64'd0, 64'd1);
                    d_pend = 1'b0; d_req = 1'b0;
                end
            end
            if (!i_pend && $urandom_range(0, 3) != 0) begin
                ia = 6'($urandom_range(0, 15));
                i_addr = {26'd0, ia};
                i_req = 1'b1; i_pend = 1'b1; i_wait = 0; i_others = 0;
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                da    = 6'($urandom_range(0, 15));
                d_pwe = 1'($urandom_range(0, 1));
                dwd   = $urandom;
                d_addr = {26'd0, da}; d_we = d_pwe; d_wdata = dwd;
                d_req = 1'b1; d_pend = 1'b1; d_wait = 0; d_others = 0;
            end
        end
        drain(20);
        // completes any store still in flight so memory can be compared
        if (d_pend && d_pwe) ref_mem[da] = dwd;
        tick();
        for (int a = 0; a < 16; a++) chk($sformatf("rnd_mem_%0d", a), mem[a], ref_mem[a]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
